// File: rtl/font_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : font_flash_reader
//  Description : Reads glyph words from an external SPI NOR font flash.
//                Issues one READ (0x03) frame per request and streams the
//                words back through a one-word output buffer with backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module font_flash_reader #(
    parameter int CLK_DIV   = 2,
    parameter int MAX_BURST = 16,
    parameter int CS_HIGH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [21:0] req_addr_i,
    input  logic [4:0]  req_len_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_last_o,
    output logic        busy_o,
    output logic        flash_cs_n_o,
    output logic        flash_sck_o,
    output logic        flash_mosi_o,
    input  logic        flash_miso_i
);

    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int CS_W  = $clog2(CS_HIGH + 1);

    // Positions inside one SPI bit period: low for CLK_DIV cycles, then high.
    localparam logic [DIV_W-1:0] c_low_last = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_sck_rise = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CS_W-1:0]  c_cs_last  = CS_W'(CS_HIGH - 1);
    localparam logic [4:0]       c_max_len  = 5'(MAX_BURST);
    localparam logic [7:0]       c_read_cmd = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_HOLD  = 3'd4,
        S_DESEL = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [4:0]        bit_q, bit_d;
    logic [4:0]        words_q, words_d;
    logic [31:0]       shift_q, shift_d;
    logic [15:0]       rx_q, rx_d;
    logic [CS_W-1:0]   cs_cnt_q, cs_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;

    logic              w_bit_end;
    logic [15:0]       w_rx_next;
    logic [4:0]        w_len;
    logic [DIV_W-1:0]  w_div_next;

    // Length clamp: zero means one word, oversize saturates to the burst limit.
    always_comb begin
        w_len = req_len_i;
        if (req_len_i == 5'd0) begin
            w_len = 5'd1;
        end else if (req_len_i > c_max_len) begin
            w_len = c_max_len;
        end
    end

    // Next-state logic for the frame sequencer, shifters and output buffer.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        words_d     = words_q;
        shift_d     = shift_q;
        rx_d        = rx_q;
        cs_cnt_d    = cs_cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;

        w_bit_end  = (div_q == c_div_last);
        w_div_next = w_bit_end ? '0 : div_q + 1'b1;
        // MISO is captured in the first high cycle of SCK.
        w_rx_next  = (div_q == c_sck_rise) ? {rx_q[14:0], flash_miso_i} : rx_q;

        if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_CMD;
                    div_d   = '0;
                    bit_d   = 5'd0;
                    words_d = w_len;
                    shift_d = {c_read_cmd, 1'b0, req_addr_i, 1'b0};
                end
            end
            S_CMD: begin
                div_d = w_div_next;
                if (w_bit_end) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    if (bit_q == 5'd7) begin
                        bit_d   = 5'd0;
                        state_d = S_ADDR;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            S_ADDR: begin
                div_d = w_div_next;
                if (w_bit_end) begin
                    shift_d = {shift_q[30:0], 1'b0};
                    if (bit_q == 5'd23) begin
                        bit_d   = 5'd0;
                        state_d = S_DATA;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            S_DATA: begin
                rx_d = w_rx_next;
                // A new word may not raise SCK while the buffer still holds
                // an unaccepted word; park with SCK low instead.
                if (bit_q == 5'd0 && div_q == c_low_last && rsp_valid_q && !rsp_ready_i) begin
                    state_d = S_HOLD;
                end else begin
                    div_d = w_div_next;
                    if (w_bit_end) begin
                        if (bit_q == 5'd15) begin
                            bit_d       = 5'd0;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = w_rx_next;
                            rsp_last_d  = (words_q == 5'd1);
                            words_d     = words_q - 5'd1;
                            if (words_q == 5'd1) begin
                                state_d  = S_DESEL;
                                cs_cnt_d = '0;
                            end
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!rsp_valid_q || rsp_ready_i) begin
                    state_d = S_DATA;
                    div_d   = c_sck_rise;
                end
            end
            S_DESEL: begin
                // Idle is only re-entered once the final word has been taken.
                if (cs_cnt_q == c_cs_last) begin
                    if (!rsp_valid_q || rsp_ready_i) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cs_cnt_d = cs_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= 5'd0;
            words_q     <= 5'd0;
            shift_q     <= 32'd0;
            rx_q        <= 16'd0;
            cs_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            words_q     <= words_d;
            shift_q     <= shift_d;
            rx_q        <= rx_d;
            cs_cnt_q    <= cs_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        req_ready_o  = (state_q == S_IDLE) && !rst;
        busy_o       = (state_q != S_IDLE);
        flash_cs_n_o = !((state_q == S_CMD) || (state_q == S_ADDR) ||
                         (state_q == S_DATA) || (state_q == S_HOLD));
        flash_sck_o  = ((state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA)) &&
                       (div_q >= c_sck_rise);
        flash_mosi_o = ((state_q == S_CMD) || (state_q == S_ADDR)) && shift_q[31];
        rsp_valid_o  = rsp_valid_q;
        rsp_data_o   = rsp_data_q;
        rsp_last_o   = rsp_last_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_font_flash_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_font_flash_reader
//  Description : Scoreboard bench for font_flash_reader with a behavioural
//                SPI flash model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_font_flash_reader;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [21:0] req_addr = 22'd0;
    logic [4:0]  req_len = 5'd0;
    logic        rsp_ready = 1'b0;
    logic        miso = 1'b0;
    logic        req_ready, rsp_valid, rsp_last, busy, cs_n, sck, mosi;
    logic [15:0] rsp_data;

    font_flash_reader #(.CLK_DIV(D), .MAX_BURST(16), .CS_HIGH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_len_i   (req_len),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_last_o  (rsp_last),
        .busy_o      (busy),
        .flash_cs_n_o(cs_n),
        .flash_sck_o (sck),
        .flash_mosi_o(mosi),
        .flash_miso_i(miso)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    int          pop_cyc[$];
    logic [15:0] mem [0:7];
    logic [31:0] mosi_cap = 32'd0;
    int          data_mosi_err = 0;
    int          frames = 0;
    int          bitn = 0;
    logic        prev_sck = 1'b0;
    logic        prev_cs = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Flash model: MISO updated while SCK is low, MOSI captured at SCK rise.
    initial forever begin
        int k;
        @(negedge clk);
        if (cs_n) begin
            bitn = 0;
        end else begin
            if (prev_cs) begin
                frames++;
                mosi_cap = 32'd0;
                bitn = 0;
            end
            if (prev_sck && !sck) bitn++;
            if (!prev_sck && sck) begin
                if (bitn < 32) mosi_cap = {mosi_cap[30:0], mosi};
                else if (mosi) data_mosi_err++;
            end
        end
        k = bitn - 32;
        miso = (!cs_n && k >= 0) ? mem[(k / 16) % 8][15 - (k % 16)] : 1'b0;
        prev_sck = sck;
        prev_cs  = cs_n;
    end

    // Monitor: every accepted response is compared with the scoreboard head.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {16'd0, rsp_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", {16'd0, rsp_data}, {16'd0, e.d});
                check("rsp_last", {31'd0, rsp_last}, {31'd0, e.l});
            end
            pop_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [15:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Request issued in cycle 0; returns in cycle 1 (after the accept edge).
    task automatic drive_req(input logic [21:0] a, input logic [4:0] l);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int to;
        to = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) begin
                to = 0;
                break;
            end
        end
        check({name, "_idle_timeout"}, to, 0);
    endtask

    initial begin
        int k;
        int base;
        int fr0;
        int viol;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 0);
        check("rst_cs_n", {31'd0, cs_n}, 1);
        check("rst_sck_mosi", {30'd0, sck, mosi}, 0);
        check("rst_rsp", {14'd0, rsp_valid, rsp_last, rsp_data}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, req_ready}, 1);

        // ---------------- single word, timing ----------------
        mem[0] = 16'hA53C;
        rsp_ready = 1'b1;
        push(16'hA53C, 1'b1);
        drive_req(22'h000100, 5'd1);
        k = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                k = c;
                break;
            end
        end
        check("t1_first_valid_cycle", k, 1 + 96 * D);
        check("t1_cs_high_at_rsp", {31'd0, cs_n}, 1);
        for (int c = 1 + 96 * D + 1; c <= 1 + 96 * D + 4; c++) begin
            @(negedge clk);
            if (c == 96 * D + 4) check("t1_ready_during_desel", {31'd0, req_ready}, 0);
            if (c == 96 * D + 5) check("t1_ready_after_desel", {31'd0, req_ready}, 1);
        end
        wait_idle("t1");
        check("t1_mosi_cmd_addr", mosi_cap, 32'h0300_0200);
        check("t1_mosi_data_zero", data_mosi_err, 0);

        // ---------------- three-word burst ----------------
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        base = pop_cyc.size();
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        push(16'h3333, 1'b1);
        drive_req(22'h000010, 5'd3);
        wait_idle("t2");
        check("t2_word_count", pop_cyc.size() - base, 3);
        if (pop_cyc.size() - base == 3) begin
            check("t2_gap_1_2", pop_cyc[base + 1] - pop_cyc[base], 32 * D);
            check("t2_gap_2_3", pop_cyc[base + 2] - pop_cyc[base + 1], 32 * D);
        end
        check("t2_mosi_cmd_addr", mosi_cap, 32'h0300_0020);

        // ---------------- backpressure ----------------
        mem[0] = 16'hC001;
        mem[1] = 16'hC002;
        mem[2] = 16'hC003;
        mem[3] = 16'hC004;
        rsp_ready = 1'b0;
        base = pop_cyc.size();
        push(16'hC001, 1'b0);
        push(16'hC002, 1'b0);
        push(16'hC003, 1'b0);
        push(16'hC004, 1'b1);
        drive_req(22'h000040, 5'd4);
        k = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                k = c;
                break;
            end
        end
        check("t3_first_valid_cycle", k, 1 + 96 * D);
        viol = 0;
        for (int j = 1; j <= 100; j++) begin
            @(negedge clk);
            if (sck || cs_n || !rsp_valid) viol++;
        end
        check("t3_hold_sck_low_cs_low", viol, 0);
        check("t3_held_data", {16'd0, rsp_data}, 32'h0000_C001);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle("t3");
        check("t3_word_count", pop_cyc.size() - base, 4);

        // ---------------- len 0, top address ----------------
        mem[0] = 16'h5AF0;
        base = pop_cyc.size();
        push(16'h5AF0, 1'b1);
        drive_req(22'h3FFFFF, 5'd0);
        wait_idle("t4");
        check("t4_word_count", pop_cyc.size() - base, 1);
        check("t4_mosi_cmd_addr", mosi_cap, 32'h037F_FFFE);

        // ---------------- reset during ADDR phase ----------------
        base = pop_cyc.size();
        drive_req(22'h123456, 5'd2);
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("t5_in_frame_before_rst", {31'd0, cs_n}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rst_cs_n_sck", {30'd0, cs_n, sck}, 32'h2);
        check("t5_rst_rsp_busy", {30'd0, rsp_valid, busy}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready_after_rst", {31'd0, req_ready}, 1);
        check("t5_no_rsp_from_aborted", pop_cyc.size() - base, 0);
        mem[0] = 16'h7E57;
        push(16'h7E57, 1'b1);
        drive_req(22'h000080, 5'd1);
        wait_idle("t5");
        check("t5_new_req_words", pop_cyc.size() - base, 1);
        check("t5_mosi_cmd_addr", mosi_cap, 32'h0300_0100);

        // ---------------- req_valid while busy ----------------
        mem[0] = 16'hBEEF;
        mem[1] = 16'h1234;
        base = pop_cyc.size();
        fr0 = frames;
        push(16'hBEEF, 1'b0);
        push(16'h1234, 1'b1);
        drive_req(22'h000200, 5'd2);
        repeat (20) @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_addr  = 22'h0AAAAA;
        req_len   = 5'd5;
        viol = 0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (req_ready) viol++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t6_ready_low_while_busy", viol, 0);
        wait_idle("t6");
        check("t6_word_count", pop_cyc.size() - base, 2);
        check("t6_frame_count", frames - fr0, 1);
        check("t6_mosi_cmd_addr", mosi_cap, 32'h0300_0400);

        check("final_scoreboard_empty", exp_q.size(), 0);
        check("final_mosi_data_zero", data_mosi_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
